reg_pattern_checker: RTL and testbench

Readback checker for the register bring-up board: watches the same active-low load request that drives the Register's `ld_ni`, and after a settle delay samples the Register's `data_o`. It compares the sample against the four-step load pattern sequence (0x0001, 0x0080, 0x00F0, 0x000F) and reports pass/fail pulses, a sticky error flag and saturating pass/fail counts for LEDs. It sits beside the Register in the board top as the consumer of its output, turning the visual LED check into a self-checking one.

---
 rtl/reg_pattern_pkg.sv | 42 ++++
 rtl/reg_pattern_checker_ld_conditioner.sv | 84 ++++++++
 rtl/reg_pattern_checker.sv | 128 ++++++++++++
 tb/tb_reg_pattern_checker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pattern_pkg.sv
// Shared definitions for the register readback checker and the board load generator:
// FSM encoding, the four-step load pattern table and counter widths.
package reg_pattern_pkg;

   localparam int unsigned PATTERN_COUNT  = 4;
   localparam int unsigned PATTERN_W      = 16;
   localparam int unsigned PATTERN_IDX_W  = 2;
   localparam int unsigned COUNT_W        = 8;
   localparam int unsigned SETTLE_CNT_W   = 8;
   localparam int unsigned DEBOUNCE_CNT_W = 16;

   localparam logic [PATTERN_W-1:0] PATTERN_0 = 16'h0001;
   localparam logic [PATTERN_W-1:0] PATTERN_1 = 16'h0080;
   localparam logic [PATTERN_W-1:0] PATTERN_2 = 16'h00F0;
   localparam logic [PATTERN_W-1:0] PATTERN_3 = 16'h000F;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_SETTLE       = 2'd1,
      ST_SAMPLE       = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_e;

   // Result bookkeeping shown on the LEDs
   typedef struct packed {
      logic [COUNT_W-1:0] pass_cnt;
      logic [COUNT_W-1:0] fail_cnt;
      logic               error;
   } check_stats_t;

   function automatic logic [PATTERN_W-1:0] pattern_value(input logic [PATTERN_IDX_W-1:0] idx);
      logic [PATTERN_W-1:0] val;
      case (idx)
         2'd0:    val = PATTERN_0;
         2'd1:    val = PATTERN_1;
         2'd2:    val = PATTERN_2;
         default: val = PATTERN_3;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/reg_pattern_checker_ld_conditioner.sv
// Load request conditioning: 2-flop synchronizer, optional debounce filter
// (enabled by REG_CHECKER_DEBOUNCE_EN) and falling-edge event detect.
module ld_conditioner
   import reg_pattern_pkg::*;
#(
   parameter int unsigned DebounceCycles = 16
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic ld_ni,
   output logic ld_level_o,
   output logic ld_fall_c
);

   if (DebounceCycles < 2 || DebounceCycles > 65535) begin : g_bad_debounce
      $error("DebounceCycles out of range 2..65535");
   end

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic ld_level;

   always_comb begin
      sync1_d = ld_ni;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef REG_CHECKER_DEBOUNCE_EN
   logic                      filt_q,   filt_d;
   logic [DEBOUNCE_CNT_W-1:0] db_cnt_q, db_cnt_d;

   // Follow the synchronized level only once it has disagreed for DebounceCycles cycles
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = '0;
      if (sync2_q != filt_q) begin
         if (db_cnt_q == DEBOUNCE_CNT_W'(DebounceCycles - 1)) begin
            filt_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + DEBOUNCE_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         filt_q   <= 1'b1;
         db_cnt_q <= '0;
      end else begin
         filt_q   <= filt_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign ld_level = filt_q;
`else
   assign ld_level = sync2_q;
`endif

   always_comb prev_d = ld_level;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign ld_level_o = ld_level;
   assign ld_fall_c  = prev_q & ~ld_level;

endmodule

// File: rtl/reg_pattern_checker.sv
// Register readback checker: after each load request settles, compares data_i with the
// expected load pattern and keeps pass/fail statistics. Debounce via REG_CHECKER_DEBOUNCE_EN.
module reg_pattern_checker
   import reg_pattern_pkg::*;
#(
   parameter int unsigned DataWidth      = 16,
   parameter int unsigned SettleCycles   = 4,
   parameter int unsigned DebounceCycles = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_ni,
   input  logic                     ld_ni,
   input  logic [DataWidth-1:0]     data_i,
   output logic [PATTERN_IDX_W-1:0] pattern_o,
   output logic                     busy_o,
   output logic                     pass_o,
   output logic                     fail_o,
   output logic                     error_o,
   output logic [COUNT_W-1:0]       pass_count_o,
   output logic [COUNT_W-1:0]       fail_count_o
);

   if (SettleCycles < 1 || SettleCycles > 255) begin : g_bad_settle
      $error("SettleCycles out of range 1..255");
   end

   logic ld_level;
   logic ld_fall;

   ld_conditioner #(
      .DebounceCycles (DebounceCycles)
   ) u_ld_conditioner (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .ld_ni      (ld_ni),
      .ld_level_o (ld_level),
      .ld_fall_c  (ld_fall)
   );

   state_e                   state_q,      state_d;
   logic [SETTLE_CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [PATTERN_IDX_W-1:0] pattern_q,    pattern_d;
   check_stats_t             stats_q,      stats_d;
   logic                     busy_q,       busy_d;
   logic                     pass_q,       pass_d;
   logic                     fail_q,       fail_d;
   logic [DataWidth-1:0]     expected;

   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      pattern_d    = pattern_q;
      stats_d      = stats_q;
      pass_d       = 1'b0;
      fail_d       = 1'b0;
      expected     = DataWidth'(pattern_value(pattern_q));

      case (state_q)
         ST_IDLE: begin
            if (ld_fall) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = SETTLE_CNT_W'(SettleCycles - 1);
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_q == '0) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q - SETTLE_CNT_W'(1);
            end
         end
         ST_SAMPLE: begin
            // Pattern index advances on every sample to stay in step with the generator
            state_d   = ST_WAIT_RELEASE;
            pattern_d = pattern_q + PATTERN_IDX_W'(1);
            if (data_i == expected) begin
               pass_d = 1'b1;
               if (stats_q.pass_cnt != '1) begin
                  stats_d.pass_cnt = stats_q.pass_cnt + COUNT_W'(1);
               end
            end else begin
               fail_d        = 1'b1;
               stats_d.error = 1'b1;
               if (stats_q.fail_cnt != '1) begin
                  stats_d.fail_cnt = stats_q.fail_cnt + COUNT_W'(1);
               end
            end
         end
         ST_WAIT_RELEASE: begin
            if (ld_level) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         pattern_q    <= '0;
         stats_q      <= '0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         pattern_q    <= pattern_d;
         stats_q      <= stats_d;
         busy_q       <= busy_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
      end
   end

   assign pattern_o    = pattern_q;
   assign busy_o       = busy_q;
   assign pass_o       = pass_q;
   assign fail_o       = fail_q;
   assign error_o      = stats_q.error;
   assign pass_count_o = stats_q.pass_cnt;
   assign fail_count_o = stats_q.fail_cnt;

endmodule

// File: tb/tb_reg_pattern_checker.sv
// Scoreboard bench for reg_pattern_checker: each load pushes its expected result,
// a negedge monitor pops and compares on every pass/fail pulse.
module tb_reg_pattern_checker;
   import reg_pattern_pkg::*;

   localparam int unsigned DW       = 16;
   localparam int unsigned SETTLE   = 4;
   localparam int unsigned DEBOUNCE = 16;
`ifdef REG_CHECKER_DEBOUNCE_EN
   localparam int unsigned DB_LAT = DEBOUNCE;
`else
   localparam int unsigned DB_LAT = 0;
`endif
   localparam int unsigned HOLD = 10 + DB_LAT;
   localparam int unsigned GAP  = 8 + DB_LAT;

   logic          clk = 1'b0;
   logic          reset_ni;
   logic          ld_ni;
   logic [DW-1:0] data_i;
   logic [1:0]    pattern_o;
   logic          busy_o, pass_o, fail_o, error_o;
   logic [7:0]    pass_count_o, fail_count_o;

   reg_pattern_checker #(
      .DataWidth      (DW),
      .SettleCycles   (SETTLE),
      .DebounceCycles (DEBOUNCE)
   ) dut (
      .clk_i        (clk),
      .reset_ni     (reset_ni),
      .ld_ni        (ld_ni),
      .data_i       (data_i),
      .pattern_o    (pattern_o),
      .busy_o       (busy_o),
      .pass_o       (pass_o),
      .fail_o       (fail_o),
      .error_o      (error_o),
      .pass_count_o (pass_count_o),
      .fail_count_o (fail_count_o)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic        is_pass;
      int unsigned cyc;
      logic [1:0]  pat;
      logic [7:0]  pcnt;
      logic [7:0]  fcnt;
      logic        err;
   } exp_t;

   exp_t sb_q[$];

   logic [15:0] exp_pattern [4] = '{16'h0001, 16'h0080, 16'h00F0, 16'h000F};
   logic [1:0]  m_idx  = 2'd0;
   logic [7:0]  m_pcnt = 8'd0;
   logic [7:0]  m_fcnt = 8'd0;
   logic        m_err  = 1'b0;

   task automatic model_reset();
      m_idx  = 2'd0;
      m_pcnt = 8'd0;
      m_fcnt = 8'd0;
      m_err  = 1'b0;
   endtask

   task automatic sb_push(input logic [15:0] data, input int unsigned e0);
      exp_t e;
      e.is_pass = (data == exp_pattern[m_idx]);
      if (e.is_pass) begin
         if (m_pcnt != 8'd255) m_pcnt = m_pcnt + 8'd1;
      end else begin
         m_err = 1'b1;
         if (m_fcnt != 8'd255) m_fcnt = m_fcnt + 8'd1;
      end
      m_idx  = m_idx + 2'd1;
      e.pat  = m_idx;
      e.pcnt = m_pcnt;
      e.fcnt = m_fcnt;
      e.err  = m_err;
      e.cyc  = e0 + 7 + DB_LAT;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (pass_o || fail_o) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_pulse", 32'({pass_o, fail_o}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq("pulse_kind", 32'({pass_o, fail_o}), e.is_pass ? 32'd2 : 32'd1);
            check_eq("pulse_cycle", 32'(cyc), 32'(e.cyc));
            check_eq("pattern_o", 32'(pattern_o), 32'(e.pat));
            check_eq("pass_count_o", 32'(pass_count_o), 32'(e.pcnt));
            check_eq("fail_count_o", 32'(fail_count_o), 32'(e.fcnt));
            check_eq("error_o", 32'(error_o), 32'(e.err));
         end
      end
   end

   task automatic do_load(input logic [15:0] data, input int unsigned hold);
      @(negedge clk);
      data_i = data;
      ld_ni  = 1'b0;
      sb_push(data, cyc + 1);
      repeat (hold) @(negedge clk);
      ld_ni = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic wait_drain();
      int budget = 200;
      while (sb_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_ni = 1'b0;
      ld_ni    = 1'b1;
      repeat (2) @(negedge clk);
      reset_ni = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
   endtask

   task automatic check_idle_state(input string tag);
      check_eq({tag, "_pattern"}, 32'(pattern_o), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
      check_eq({tag, "_pass"}, 32'(pass_o), 32'd0);
      check_eq({tag, "_fail"}, 32'(fail_o), 32'd0);
      check_eq({tag, "_error"}, 32'(error_o), 32'd0);
      check_eq({tag, "_pcnt"}, 32'(pass_count_o), 32'd0);
      check_eq({tag, "_fcnt"}, 32'(fail_count_o), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] pat_before;
      reset_ni = 1'b0;
      ld_ni    = 1'b1;
      data_i   = '0;
      repeat (3) @(negedge clk);
      check_idle_state("reset");
      reset_ni = 1'b1;
      repeat (3) @(negedge clk);

      // Full passing sequence
      for (int i = 0; i < 4; i++) do_load(exp_pattern[i], HOLD);
      wait_drain();
      check_eq("seq_pcnt", 32'(pass_count_o), 32'd4);
      check_eq("seq_pattern", 32'(pattern_o), 32'd0);
      check_eq("seq_error", 32'(error_o), 32'd0);
      check_eq("seq_busy", 32'(busy_o), 32'd0);

      // Failing first load, then sticky error through passes
      apply_reset();
      do_load(16'h0002, HOLD);
      wait_drain();
      check_eq("fail_fcnt", 32'(fail_count_o), 32'd1);
      check_eq("fail_error", 32'(error_o), 32'd1);
      check_eq("fail_pattern", 32'(pattern_o), 32'd1);
      for (int i = 1; i < 4; i++) do_load(exp_pattern[i], HOLD);
      wait_drain();
      check_eq("sticky_error", 32'(error_o), 32'd1);
      check_eq("sticky_pcnt", 32'(pass_count_o), 32'd3);

      // Second falling edge while settling is ignored
      pat_before = pattern_o;
      @(negedge clk);
      data_i = exp_pattern[m_idx];
      ld_ni  = 1'b0;
      sb_push(data_i, cyc + 1);
      repeat (3 + DB_LAT) @(negedge clk);
      check_eq("settle_busy", 32'(busy_o), 32'd1);
      ld_ni = 1'b1;
      @(negedge clk);
      ld_ni = 1'b0;
      repeat (HOLD) @(negedge clk);
      ld_ni = 1'b1;
      repeat (GAP) @(negedge clk);
      wait_drain();
      check_eq("settle_pattern", 32'(pattern_o), 32'(pat_before + 2'd1));

      // Reset in the middle of SETTLE aborts the check
      @(negedge clk);
      data_i = exp_pattern[m_idx];
      ld_ni  = 1'b0;
      repeat (3 + DB_LAT) @(negedge clk);
      check_eq("midreset_busy", 32'(busy_o), 32'd1);
      reset_ni = 1'b0;
      ld_ni    = 1'b1;
      @(negedge clk);
      check_idle_state("midreset");
      reset_ni = 1'b1;
      model_reset();
      repeat (GAP + 10) @(negedge clk);
      check_eq("midreset_quiet_busy", 32'(busy_o), 32'd0);

      // Fail count saturation
      for (int i = 0; i < 260; i++) do_load(16'hFFFF, HOLD);
      wait_drain();
      check_eq("sat_fcnt", 32'(fail_count_o), 32'd255);
      check_eq("sat_error", 32'(error_o), 32'd1);

`ifdef REG_CHECKER_DEBOUNCE_EN
      // Short glitch filtered, long low accepted
      apply_reset();
      @(negedge clk);
      data_i = exp_pattern[0];
      ld_ni  = 1'b0;
      repeat (10) @(negedge clk);
      ld_ni = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("glitch_busy", 32'(busy_o), 32'd0);
      check_eq("glitch_pattern", 32'(pattern_o), 32'd0);
      do_load(exp_pattern[0], 40);
      wait_drain();
      check_eq("debounce_pcnt", 32'(pass_count_o), 32'd1);
`endif

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
